fmac_norm_pipe: RTL and testbench

- Consumer of the leading-one anticipation (LZA) result in the FMAC datapath.
- Takes the unnormalized adder mantissa, the anticipated leading-zero count and the pre-normalization exponent.
- Performs the coarse left shift, then the 1-bit LZA error correction, with exponent adjustment and denormal clamping.
- Two-stage valid/ready pipeline between the adder/LZA stage and the rounding stage.

---
 rtl/fpu_defs_fmac.sv | 22 ++
 rtl/fmac_norm_shift.sv | 44 ++++
 rtl/fmac_norm_pipe.sv | 120 ++++++++++++
 tb/tb_fmac_norm_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_defs_fmac.sv
// Shared constants and record types for the FMAC normalization stage.
// The shift-count width is fixed here and is not overridable.
package fpu_defs_fmac;

    localparam int C_LEADONE_WIDTH = 7;
    localparam int C_EXP_WIDTH_DEF = 10;
    localparam int C_WIDTH_DEF     = 74;

    typedef struct packed {
        logic [C_WIDTH_DEF-1:0]     mant;
        logic [C_LEADONE_WIDTH-1:0] lzc;
        logic [C_EXP_WIDTH_DEF-1:0] exp;
    } norm_in_t;

    typedef struct packed {
        logic [C_WIDTH_DEF-1:0]     mant;
        logic [C_EXP_WIDTH_DEF-1:0] exp;
        logic                       denorm;
        logic                       zero;
    } norm_out_t;

endpackage

// File: rtl/fmac_norm_shift.sv
// Stage-1 coarse normalization: clamps the anticipated shift against the exponent
// and the mantissa width, then barrel-shifts the mantissa left.
module fmac_norm_shift
    import fpu_defs_fmac::*;
#(
    parameter int C_WIDTH     = C_WIDTH_DEF,
    parameter int C_EXP_WIDTH = C_EXP_WIDTH_DEF
) (
    input  logic [C_WIDTH-1:0]         mant,
    input  logic [C_LEADONE_WIDTH-1:0] lzc,
    input  logic [C_EXP_WIDTH-1:0]     exp,
    output logic [C_WIDTH-1:0]         mant_sh,
    output logic [C_EXP_WIDTH-1:0]     exp_sh,
    output logic                       clamp,
    output logic                       zero
);

    localparam int SW = (C_EXP_WIDTH > C_LEADONE_WIDTH) ? C_EXP_WIDTH : C_LEADONE_WIDTH;

    logic          exp_le1;
    logic [SW-1:0] lzc_ext;
    logic [SW-1:0] exp_m1;
    logic [SW-1:0] cap;
    logic [SW-1:0] sh;

    // exp_m1 is only consumed when exp > 1, so the zero-extension is safe.
    assign exp_le1 = $signed(exp) <= $signed(C_EXP_WIDTH'(1));
    assign lzc_ext = SW'(lzc);
    assign exp_m1  = SW'(exp - C_EXP_WIDTH'(1));
    assign cap     = SW'(C_WIDTH - 1);

    always_comb begin
        sh = lzc_ext;
        if (exp_m1 < sh) sh = exp_m1;
        if (cap < sh) sh = cap;
        if (exp_le1) sh = '0;
    end

    assign mant_sh = mant << sh;
    assign exp_sh  = exp - C_EXP_WIDTH'(sh);
    assign clamp   = (sh < lzc_ext) | exp_le1;
    assign zero    = ~|mant;

endmodule

// File: rtl/fmac_norm_pipe.sv
// Two-stage normalization pipeline: coarse LZA-driven shift, then the 1-bit
// LZA error correction with exponent adjustment and denormal clamping.
module fmac_norm_pipe
    import fpu_defs_fmac::*;
#(
    parameter int C_WIDTH     = C_WIDTH_DEF,
    parameter int C_EXP_WIDTH = C_EXP_WIDTH_DEF
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic                       Flush_SI,
    input  logic                       Valid_SI,
    output logic                       Ready_SO,
    input  logic [C_WIDTH-1:0]         Mant_DI,
    input  logic [C_LEADONE_WIDTH-1:0] Lzc_DI,
    input  logic [C_EXP_WIDTH-1:0]     Exp_DI,
    output logic                       Valid_SO,
    input  logic                       Ready_SI,
    output logic [C_WIDTH-1:0]         Mant_DO,
    output logic [C_EXP_WIDTH-1:0]     Exp_DO,
    output logic                       Denorm_SO,
    output logic                       Zero_SO
);

    logic [C_WIDTH-1:0]     sh_mant;
    logic [C_EXP_WIDTH-1:0] sh_exp;
    logic                   sh_clamp;
    logic                   sh_zero;

    logic                   v1;
    logic [C_WIDTH-1:0]     m1;
    logic [C_EXP_WIDTH-1:0] e1;
    logic                   c1;
    logic                   z1;

    logic                   ld1;
    logic                   ld2;

    logic [C_WIDTH-1:0]     n_mant;
    logic [C_EXP_WIDTH-1:0] n_exp;
    logic                   n_denorm;
    logic                   n_zero;

    fmac_norm_shift #(
        .C_WIDTH     (C_WIDTH),
        .C_EXP_WIDTH (C_EXP_WIDTH)
    ) u_shift (
        .mant    (Mant_DI),
        .lzc     (Lzc_DI),
        .exp     (Exp_DI),
        .mant_sh (sh_mant),
        .exp_sh  (sh_exp),
        .clamp   (sh_clamp),
        .zero    (sh_zero)
    );

    // Valid/ready: a transfer happens on any edge where valid and ready are both
    // high; valid never depends on ready; Ready_SO is combinational from Ready_SI.
    assign ld2      = v1 & (~Valid_SO | Ready_SI);
    assign Ready_SO = ~v1 | ~Valid_SO | Ready_SI;
    assign ld1      = Valid_SI & Ready_SO;

    always_comb begin
        n_mant   = m1;
        n_exp    = e1;
        n_denorm = 1'b0;
        n_zero   = 1'b0;
        if (z1) begin
            n_mant = '0;
            n_exp  = '0;
            n_zero = 1'b1;
        end else if (!m1[C_WIDTH-1]) begin
            if ($signed(e1) > $signed(C_EXP_WIDTH'(1))) begin
                n_mant   = m1 << 1;
                n_exp    = e1 - C_EXP_WIDTH'(1);
                n_denorm = c1;
            end else begin
                n_denorm = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            v1        <= 1'b0;
            m1        <= '0;
            e1        <= '0;
            c1        <= 1'b0;
            z1        <= 1'b0;
            Valid_SO  <= 1'b0;
            Mant_DO   <= '0;
            Exp_DO    <= '0;
            Denorm_SO <= 1'b0;
            Zero_SO   <= 1'b0;
        end else if (Flush_SI) begin
            v1       <= 1'b0;
            Valid_SO <= 1'b0;
        end else begin
            if (ld1) begin
                v1 <= 1'b1;
                m1 <= sh_mant;
                e1 <= sh_exp;
                c1 <= sh_clamp;
                z1 <= sh_zero;
            end else if (ld2) begin
                v1 <= 1'b0;
            end
            if (ld2) begin
                Valid_SO  <= 1'b1;
                Mant_DO   <= n_mant;
                Exp_DO    <= n_exp;
                Denorm_SO <= n_denorm;
                Zero_SO   <= n_zero;
            end else if (Ready_SI) begin
                Valid_SO <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmac_norm_pipe.sv
// Self-checking bench for fmac_norm_pipe: directed cases, back-pressure,
// flush/reset, then randomized traffic against a true-leading-zero model.
module tb_fmac_norm_pipe;
    import fpu_defs_fmac::*;

    localparam int W  = C_WIDTH_DEF;
    localparam int EW = C_EXP_WIDTH_DEF;

    logic                       Clk_CI = 1'b0;
    logic                       Rst_RI;
    logic                       Flush_SI;
    logic                       Valid_SI;
    logic                       Ready_SO;
    logic [W-1:0]               Mant_DI;
    logic [C_LEADONE_WIDTH-1:0] Lzc_DI;
    logic [EW-1:0]              Exp_DI;
    logic                       Valid_SO;
    logic                       Ready_SI;
    logic [W-1:0]               Mant_DO;
    logic [EW-1:0]              Exp_DO;
    logic                       Denorm_SO;
    logic                       Zero_SO;

    fmac_norm_pipe dut (
        .Clk_CI    (Clk_CI),
        .Rst_RI    (Rst_RI),
        .Flush_SI  (Flush_SI),
        .Valid_SI  (Valid_SI),
        .Ready_SO  (Ready_SO),
        .Mant_DI   (Mant_DI),
        .Lzc_DI    (Lzc_DI),
        .Exp_DI    (Exp_DI),
        .Valid_SO  (Valid_SO),
        .Ready_SI  (Ready_SI),
        .Mant_DO   (Mant_DO),
        .Exp_DO    (Exp_DO),
        .Denorm_SO (Denorm_SO),
        .Zero_SO   (Zero_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    norm_out_t exp_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    logic      stalled  = 1'b0;
    norm_out_t held;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Result as a full normalizer would produce it: shift by the true leading-zero
    // count, limited so the exponent never drops below 1.
    function automatic norm_out_t model(input logic [W-1:0] m, input logic [EW-1:0] e_in);
        norm_out_t r;
        int e, lz, sh;
        r = '0;
        if (m == '0) begin
            r.zero = 1'b1;
            return r;
        end
        e  = int'($signed(e_in));
        lz = 0;
        while (!m[W-1-lz]) lz++;
        if (e <= 1) sh = 0;
        else sh = (lz < e - 1) ? lz : e - 1;
        r.mant   = m << sh;
        r.exp    = EW'(e - sh);
        r.denorm = (lz > sh);
        return r;
    endfunction

    function automatic norm_in_t gen_item();
        norm_in_t     d;
        logic [W-1:0] lead, r;
        int           lz;
        r = {$urandom(), $urandom(), $urandom()};
        d.exp = EW'($urandom_range(0, 340) - 40);
        if ($urandom_range(0, 15) == 0) begin
            d.mant = '0;
            d.lzc  = C_LEADONE_WIDTH'($urandom_range(W, 127));
        end else begin
            lz     = $urandom_range(0, W - 1);
            lead   = W'(1) << (W - 1 - lz);
            d.mant = lead | (r & (lead - W'(1)));
            d.lzc  = C_LEADONE_WIDTH'((lz > 0 && $urandom_range(0, 1) == 1) ? lz - 1 : lz);
        end
        return d;
    endfunction

    // One clock: drive, observe outputs and Ready_SO, score, then advance.
    task automatic cycle(input logic v, input norm_in_t d, input logic rdy, input logic fl,
                         input logic rs, output logic acc);
        norm_out_t obs, e;
        Valid_SI = v;
        Mant_DI  = d.mant;
        Lzc_DI   = d.lzc;
        Exp_DI   = d.exp;
        Ready_SI = rdy;
        Flush_SI = fl;
        Rst_RI   = rs;
        #1;
        obs = '{mant: Mant_DO, exp: Exp_DO, denorm: Denorm_SO, zero: Zero_SO};
        if (stalled) begin
            check("hold_valid", 128'(Valid_SO), 128'(1));
            check("hold_data", 128'(obs), 128'(held));
        end
        stalled = 1'b0;
        if (Valid_SO && rdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 128'(Valid_SO), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_mant", 128'(Mant_DO), 128'(e.mant));
                check("out_exp", 128'(Exp_DO), 128'(e.exp));
                check("out_denorm", 128'(Denorm_SO), 128'(e.denorm));
                check("out_zero", 128'(Zero_SO), 128'(e.zero));
            end
        end
        acc = v & Ready_SO & ~fl & ~rs;
        if (acc) exp_q.push_back(model(d.mant, d.exp));
        if (fl || rs) exp_q.delete();
        else if (Valid_SO && !rdy) begin
            stalled = 1'b1;
            held    = obs;
        end
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic run_dir(input string name, input logic [W-1:0] m, input int lzc, input int e,
                           input logic [W-1:0] em, input int ee, input logic ed, input logic ez);
        norm_in_t d;
        logic     acc;
        d.mant = m;
        d.lzc  = C_LEADONE_WIDTH'(lzc);
        d.exp  = EW'(e);
        cycle(1'b1, d, 1'b1, 1'b0, 1'b0, acc);
        check({name, "_accept"}, 128'(acc), 128'(1));
        check({name, "_lat1"}, 128'(Valid_SO), 128'(0));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        check({name, "_valid"}, 128'(Valid_SO), 128'(1));
        check({name, "_mant"}, 128'(Mant_DO), 128'(em));
        check({name, "_exp"}, 128'(Exp_DO), 128'(EW'(ee)));
        check({name, "_denorm"}, 128'(Denorm_SO), 128'(ed));
        check({name, "_zero"}, 128'(Zero_SO), 128'(ez));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    initial begin
        norm_in_t items[4];
        norm_in_t d;
        logic     acc;
        int       idx;

        Rst_RI   = 1'b1;
        Flush_SI = 1'b0;
        Valid_SI = 1'b0;
        Ready_SI = 1'b1;
        Mant_DI  = '0;
        Lzc_DI   = '0;
        Exp_DI   = '0;
        repeat (2) @(posedge Clk_CI);
        #1;
        Rst_RI = 1'b0;
        #1;
        check("rst_valid", 128'(Valid_SO), 128'(0));
        check("rst_mant", 128'(Mant_DO), 128'(0));
        check("rst_exp", 128'(Exp_DO), 128'(0));
        check("rst_flags", 128'({Denorm_SO, Zero_SO}), 128'(0));
        check("rst_ready", 128'(Ready_SO), 128'(1));

        run_dir("exact", W'(1) << 70, 3, 100, W'(1) << 73, 97, 1'b0, 1'b0);
        run_dir("lzaerr", W'(1) << 69, 3, 100, W'(1) << 73, 96, 1'b0, 1'b0);
        run_dir("denorm", W'(1) << 68, 5, 2, W'(1) << 69, 1, 1'b1, 1'b0);
        run_dir("zero", '0, 74, 50, '0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            items[i].mant = (W'(1) << 73) | W'(i);
            items[i].lzc  = '0;
            items[i].exp  = EW'(10 + i);
        end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, items[idx], 1'b0, 1'b0, 1'b0, acc);
            if (c >= 2) check("bp_ready_low", 128'(acc), 128'(0));
            if (acc) idx++;
        end
        check("bp_accepts", 128'(idx), 128'(2));
        for (int c = 0; c < 4; c++) begin
            check("bp_order_valid", 128'(Valid_SO), 128'(1));
            check("bp_order_exp", 128'(Exp_DO), 128'(10 + c));
            cycle(idx < 4, items[idx < 4 ? idx : 3], 1'b1, 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_all_in", 128'(idx), 128'(4));
        check("bp_drained", 128'(Valid_SO), 128'(0));

        cycle(1'b1, gen_item(), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, gen_item(), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, gen_item(), 1'b0, 1'b1, 1'b0, acc);
        Flush_SI = 1'b0;
        #1;
        check("flush_valid", 128'(Valid_SO), 128'(0));
        check("flush_ready", 128'(Ready_SO), 128'(1));
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            check("flush_quiet", 128'(Valid_SO), 128'(0));
        end

        cycle(1'b1, gen_item(), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, gen_item(), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, gen_item(), 1'b0, 1'b0, 1'b1, acc);
        Rst_RI = 1'b0;
        #1;
        check("mrst_valid", 128'(Valid_SO), 128'(0));
        check("mrst_data", 128'({Mant_DO, Exp_DO, Denorm_SO, Zero_SO}), 128'(0));
        check("mrst_ready", 128'(Ready_SO), 128'(1));
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
            check("mrst_quiet", 128'(Valid_SO), 128'(0));
        end

        for (int c = 0; c < 500; c++) begin
            d = gen_item();
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 60) == 0, 1'b0, acc);
        end
        Flush_SI = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
        end
        check("final_drain", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
